// File: rtl/gpu_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// gpu_mem_pkg
// Shared definitions for the GPU memory-port arbiter: FSM state encoding,
// memory-bus field widths, command size codes and a small wrap helper.
// No ports (package).
// ---------------------------------------------------------------------------
package gpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_e;

  localparam int MEM_ADR_W    = 15;
  localparam int MEM_SUBADR_W = 3;
  localparam int MEM_MASK_W   = 16;
  localparam int MEM_DATA_W   = 256;
  localparam int MEM_SIZE_W   = 2;

  localparam logic [MEM_SIZE_W-1:0] SIZE_8B  = 2'd0;
  localparam logic [MEM_SIZE_W-1:0] SIZE_32B = 2'd1;

  // Next index after v in a ring of n entries.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 32'sd1 >= n) ? 32'sd0 : v + 32'sd1;
  endfunction

endpackage

// File: rtl/gpu_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// gpu_mem_arbiter_if
// Bundles the per-client request/return signals and the shared memory
// command port. Client fields are packed, client c occupying slice c.
// Modports:
//   slave  - the arbiter (consumes i_* signals, drives o_* signals)
//   master - the environment: clients plus memory controller
// ---------------------------------------------------------------------------
interface gpu_mem_arbiter_if #(
  parameter int NB_CLIENT = 3
);
  import gpu_mem_pkg::*;

  // Client side
  logic [NB_CLIENT-1:0]              i_cl_command;
  logic [NB_CLIENT-1:0]              o_cl_busy;
  logic [MEM_SIZE_W*NB_CLIENT-1:0]   i_cl_commandSize;
  logic [NB_CLIENT-1:0]              i_cl_write;
  logic [MEM_ADR_W*NB_CLIENT-1:0]    i_cl_adr;
  logic [MEM_SUBADR_W*NB_CLIENT-1:0] i_cl_subadr;
  logic [MEM_MASK_W*NB_CLIENT-1:0]   i_cl_writeMask;
  logic [MEM_DATA_W*NB_CLIENT-1:0]   i_cl_dataOut;
  logic [NB_CLIENT-1:0]              o_cl_dataInValid;
  logic [MEM_DATA_W-1:0]             o_cl_dataIn;

  // Memory side
  logic                              o_command;
  logic                              i_busy;
  logic [MEM_SIZE_W-1:0]             o_commandSize;
  logic                              o_write;
  logic [MEM_ADR_W-1:0]              o_adr;
  logic [MEM_SUBADR_W-1:0]           o_subadr;
  logic [MEM_MASK_W-1:0]             o_writeMask;
  logic [MEM_DATA_W-1:0]             o_dataOut;
  logic [MEM_DATA_W-1:0]             i_dataIn;
  logic                              i_dataInValid;

  modport slave (
    input  i_cl_command, i_cl_commandSize, i_cl_write, i_cl_adr, i_cl_subadr,
           i_cl_writeMask, i_cl_dataOut, i_busy, i_dataIn, i_dataInValid,
    output o_cl_busy, o_cl_dataInValid, o_cl_dataIn, o_command, o_commandSize,
           o_write, o_adr, o_subadr, o_writeMask, o_dataOut
  );

  modport master (
    output i_cl_command, i_cl_commandSize, i_cl_write, i_cl_adr, i_cl_subadr,
           i_cl_writeMask, i_cl_dataOut, i_busy, i_dataIn, i_dataInValid,
    input  o_cl_busy, o_cl_dataInValid, o_cl_dataIn, o_command, o_commandSize,
           o_write, o_adr, o_subadr, o_writeMask, o_dataOut
  );

endinterface

// File: rtl/gpu_mem_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// gpu_rr_pick
// Combinational round-robin finder: selects the first set bit of req at or
// after ptr, wrapping modulo NB_CLIENT.
// Ports:
//   req    in  NB_CLIENT  request vector
//   ptr    in  GRANT_W    starting index (must be < NB_CLIENT)
//   onehot out NB_CLIENT  selected requester, zero when req is empty
//   idx    out GRANT_W    index of selected requester, zero when req is empty
// ---------------------------------------------------------------------------
module gpu_rr_pick #(
  parameter int NB_CLIENT = 3,
  parameter int GRANT_W   = 3
) (
  input  logic [NB_CLIENT-1:0] req,
  input  logic [GRANT_W-1:0]   ptr,
  output logic [NB_CLIENT-1:0] onehot,
  output logic [GRANT_W-1:0]   idx
);

  // Scan clients in priority order ptr, ptr+1, ... and keep the first hit.
  always_comb begin
    logic found;
    logic take;
    int   c;
    onehot = {NB_CLIENT{1'b0}};
    idx    = {GRANT_W{1'b0}};
    found  = 1'b0;
    take   = 1'b0;
    c      = 0;
    for (int i = 0; i < NB_CLIENT; i++) begin
      c         = (int'(ptr) + i) % NB_CLIENT;
      take      = req[c] & ~found;
      onehot[c] = take;
      idx       = take ? GRANT_W'(c) : idx;
      found     = found | req[c];
    end
  end

endmodule

// File: rtl/gpu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// gpu_mem_arbiter
// Shares one DDR command port between NB_CLIENT GPU state machines with a
// registered round-robin grant. Each grant carries exactly one memory
// transaction; a read keeps the grant until its data strobe returns so the
// strobe always goes to the client that issued the read.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   bus            client fields and memory command port (slave modport)
//   o_grantValid   a client currently owns the port
//   o_grantIdx     index of the owning client
//   o_protocolErr  sticky: read data arrived with no read outstanding
// ---------------------------------------------------------------------------
module gpu_mem_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int NB_CLIENT = 3,
  parameter int GRANT_W   = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  gpu_mem_arbiter_if.slave    bus,
  output logic                o_grantValid,
  output logic [GRANT_W-1:0]  o_grantIdx,
  output logic                o_protocolErr
);

  arb_state_e               state_r, state_s;
  logic [GRANT_W-1:0]       grant_r, grant_s;
  logic [GRANT_W-1:0]       rr_ptr_r, rr_ptr_s;
  logic                     err_r;

  logic [NB_CLIENT-1:0]     pick_onehot_s;
  logic [GRANT_W-1:0]       pick_idx_s;
  logic                     pick_any_s;
  logic [NB_CLIENT-1:0]     grant_oh_s;
  logic [GRANT_W-1:0]       ptr_after_s;

  logic                     sel_cmd_s;
  logic                     sel_write_s;
  logic [MEM_SIZE_W-1:0]    sel_size_s;
  logic [MEM_ADR_W-1:0]     sel_adr_s;
  logic [MEM_SUBADR_W-1:0]  sel_subadr_s;
  logic [MEM_MASK_W-1:0]    sel_mask_s;
  logic [MEM_DATA_W-1:0]    sel_data_s;

  logic                     fields_en_s;
  logic                     mem_cmd_s;
  logic [NB_CLIENT-1:0]     cl_busy_s;
  logic [NB_CLIENT-1:0]     cl_dv_s;

  gpu_rr_pick #(
    .NB_CLIENT (NB_CLIENT),
    .GRANT_W   (GRANT_W)
  ) u_pick (
    .req    (bus.i_cl_command),
    .ptr    (rr_ptr_r),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s)
  );

  assign pick_any_s  = |pick_onehot_s;
  assign ptr_after_s = GRANT_W'(wrap_inc(int'(grant_r), NB_CLIENT));

  // Decode the registered grant index into a one-hot client select.
  always_comb begin
    grant_oh_s = {NB_CLIENT{1'b0}};
    for (int c = 0; c < NB_CLIENT; c++) begin
      grant_oh_s[c] = (grant_r == GRANT_W'(c));
    end
  end

  // AND-OR mux of the granted client's request fields.
  always_comb begin
    sel_cmd_s    = 1'b0;
    sel_write_s  = 1'b0;
    sel_size_s   = {MEM_SIZE_W{1'b0}};
    sel_adr_s    = {MEM_ADR_W{1'b0}};
    sel_subadr_s = {MEM_SUBADR_W{1'b0}};
    sel_mask_s   = {MEM_MASK_W{1'b0}};
    sel_data_s   = {MEM_DATA_W{1'b0}};
    for (int c = 0; c < NB_CLIENT; c++) begin
      sel_cmd_s    = sel_cmd_s   | (bus.i_cl_command[c] & grant_oh_s[c]);
      sel_write_s  = sel_write_s | (bus.i_cl_write[c]   & grant_oh_s[c]);
      sel_size_s   = sel_size_s   | (bus.i_cl_commandSize[c*MEM_SIZE_W +: MEM_SIZE_W]
                                     & {MEM_SIZE_W{grant_oh_s[c]}});
      sel_adr_s    = sel_adr_s    | (bus.i_cl_adr[c*MEM_ADR_W +: MEM_ADR_W]
                                     & {MEM_ADR_W{grant_oh_s[c]}});
      sel_subadr_s = sel_subadr_s | (bus.i_cl_subadr[c*MEM_SUBADR_W +: MEM_SUBADR_W]
                                     & {MEM_SUBADR_W{grant_oh_s[c]}});
      sel_mask_s   = sel_mask_s   | (bus.i_cl_writeMask[c*MEM_MASK_W +: MEM_MASK_W]
                                     & {MEM_MASK_W{grant_oh_s[c]}});
      sel_data_s   = sel_data_s   | (bus.i_cl_dataOut[c*MEM_DATA_W +: MEM_DATA_W]
                                     & {MEM_DATA_W{grant_oh_s[c]}});
    end
  end

  // Arbiter FSM: next state, next grant/pointer and port-side outputs.
  always_comb begin
    state_s     = state_r;
    grant_s     = grant_r;
    rr_ptr_s    = rr_ptr_r;
    fields_en_s = 1'b0;
    mem_cmd_s   = 1'b0;
    cl_busy_s   = {NB_CLIENT{1'b1}};
    cl_dv_s     = {NB_CLIENT{1'b0}};
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          state_s = OWN;
          grant_s = pick_idx_s;
        end else begin
          state_s = IDLE;
        end
      end
      OWN: begin
        fields_en_s = 1'b1;
        mem_cmd_s   = sel_cmd_s;
        // Only the owner sees the real memory busy; everyone else is held off.
        cl_busy_s   = ~grant_oh_s | {NB_CLIENT{bus.i_busy}};
        if (!sel_cmd_s) begin
          state_s  = IDLE;
          rr_ptr_s = ptr_after_s;
        end else if (!bus.i_busy) begin
          if (sel_write_s) begin
            state_s  = IDLE;
            rr_ptr_s = ptr_after_s;
          end else begin
            state_s  = WAIT_RD;
          end
        end else begin
          state_s = OWN;
        end
      end
      WAIT_RD: begin
        if (bus.i_dataInValid) begin
          cl_dv_s  = grant_oh_s;
          state_s  = IDLE;
          rr_ptr_s = ptr_after_s;
        end else begin
          state_s = WAIT_RD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r  <= IDLE;
      grant_r  <= {GRANT_W{1'b0}};
      rr_ptr_r <= {GRANT_W{1'b0}};
    end else begin
      state_r  <= state_s;
      grant_r  <= grant_s;
      rr_ptr_r <= rr_ptr_s;
    end
  end

  // Sticky flag: read data returned while no read was outstanding.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_r <= 1'b0;
    end else if (bus.i_dataInValid && (state_r != WAIT_RD)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign bus.o_command        = mem_cmd_s;
  assign bus.o_write          = fields_en_s & sel_write_s;
  assign bus.o_commandSize    = fields_en_s ? sel_size_s   : {MEM_SIZE_W{1'b0}};
  assign bus.o_adr            = fields_en_s ? sel_adr_s    : {MEM_ADR_W{1'b0}};
  assign bus.o_subadr         = fields_en_s ? sel_subadr_s : {MEM_SUBADR_W{1'b0}};
  assign bus.o_writeMask      = fields_en_s ? sel_mask_s   : {MEM_MASK_W{1'b0}};
  assign bus.o_dataOut        = fields_en_s ? sel_data_s   : {MEM_DATA_W{1'b0}};
  assign bus.o_cl_busy        = cl_busy_s;
  assign bus.o_cl_dataInValid = cl_dv_s;
  assign bus.o_cl_dataIn      = bus.i_dataIn;

  assign o_grantValid  = (state_r != IDLE);
  assign o_grantIdx    = grant_r;
  assign o_protocolErr = err_r;

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gpu_mem_arbiter
// Directed bench for gpu_mem_arbiter. Expected memory accepts and expected
// read strobes are queued when stimulus is driven; a negedge monitor pops
// and compares them when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_gpu_mem_arbiter;
  import gpu_mem_pkg::*;

  localparam int NB = 3;
  localparam int GW = 3;

  localparam logic [255:0] D1 = {8{32'hA1A1_0001}};
  localparam logic [255:0] D2 = {8{32'hB2B2_0002}};
  localparam logic [255:0] D3 = {8{32'hC3C3_0003}};
  localparam logic [255:0] D4 = {8{32'hD4D4_0004}};
  localparam logic [255:0] D5 = {8{32'hE5E5_0005}};
  localparam logic [255:0] D6 = {8{32'hF6F6_0006}};
  localparam logic [255:0] D7 = {8{32'h1717_0007}};

  logic          clk = 1'b0;
  logic          rst;
  logic          grant_valid;
  logic [GW-1:0] grant_idx;
  logic          proto_err;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  logic [18:0]  acc_q[$];   // {grant idx, adr, write}
  logic [258:0] rd_q[$];    // {strobe vector, data}
  logic [18:0]  mon_acc;
  logic [258:0] mon_rd;

  gpu_mem_arbiter_if #(.NB_CLIENT(NB)) bus();

  gpu_mem_arbiter #(.NB_CLIENT(NB), .GRANT_W(GW)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .bus           (bus),
    .o_grantValid  (grant_valid),
    .o_grantIdx    (grant_idx),
    .o_protocolErr (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_cl(input int c, input logic cmd, input logic wr,
                        input logic [14:0] adr, input logic [255:0] data);
    bus.i_cl_command[c]           = cmd;
    bus.i_cl_write[c]             = wr;
    bus.i_cl_adr[c*15 +: 15]      = adr;
    bus.i_cl_dataOut[c*256 +: 256] = data;
    bus.i_cl_commandSize[c*2 +: 2] = SIZE_32B;
    bus.i_cl_subadr[c*3 +: 3]     = 3'(c);
    bus.i_cl_writeMask[c*16 +: 16] = 16'hFFFF;
  endtask

  task automatic push_acc(input int c, input logic [14:0] adr, input logic wr);
    acc_q.push_back({3'(c), adr, wr});
  endtask

  // Scoreboard monitor: every accept and every client strobe must be expected.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.o_command === 1'b1 && bus.i_busy === 1'b0) begin
        chk("acc_expected", 256'(acc_q.size() != 0), 256'd1);
        if (acc_q.size() != 0) begin
          mon_acc = acc_q.pop_front();
          chk("acc_fields", 256'({grant_idx, bus.o_adr, bus.o_write}), 256'(mon_acc));
        end
      end
      if (bus.o_cl_dataInValid !== 3'b000) begin
        chk("rd_expected", 256'(rd_q.size() != 0), 256'd1);
        if (rd_q.size() != 0) begin
          mon_rd = rd_q.pop_front();
          chk("rd_strobe", 256'(bus.o_cl_dataInValid), 256'(mon_rd[258:256]));
          chk("rd_data", bus.o_cl_dataIn, mon_rd[255:0]);
        end
      end
    end
  end

  initial begin
    int n;
    rst                  = 1'b1;
    bus.i_cl_command     = 3'b000;
    bus.i_cl_write       = 3'b000;
    bus.i_cl_commandSize = 6'd0;
    bus.i_cl_adr         = 45'd0;
    bus.i_cl_subadr      = 9'd0;
    bus.i_cl_writeMask   = 48'd0;
    bus.i_cl_dataOut     = 768'd0;
    bus.i_busy           = 1'b0;
    bus.i_dataIn         = 256'd0;
    bus.i_dataInValid    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    smp();
    chk("rst_busy", 256'(bus.o_cl_busy), 256'(3'b111));
    chk("rst_cmd", 256'(bus.o_command), 256'd0);
    chk("rst_gvalid", 256'(grant_valid), 256'd0);
    chk("rst_gidx", 256'(grant_idx), 256'd0);
    chk("rst_err", 256'(proto_err), 256'd0);
    chk("rst_dv", 256'(bus.o_cl_dataInValid), 256'd0);
    chk("rst_adr", 256'(bus.o_adr), 256'd0);
    chk("rst_dout", bus.o_dataOut, 256'd0);
    mon_en = 1'b1;

    // Single client-1 read, data returns 4 cycles after accept.
    push_acc(1, 15'h1234, 1'b0);
    cyc(); set_cl(1, 1'b1, 1'b0, 15'h1234, D1);
    smp(); chk("t1_latency_cmd", 256'(bus.o_command), 256'd0);
    cyc();
    smp();
    chk("t1_adr", 256'(bus.o_adr), 256'h1234);
    chk("t1_write", 256'(bus.o_write), 256'd0);
    chk("t1_gidx", 256'(grant_idx), 256'd1);
    chk("t1_busy_own", 256'(bus.o_cl_busy), 256'(3'b101));
    cyc(); set_cl(1, 1'b0, 1'b0, 15'h1234, D1);
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("t1_wait_busy", 256'(bus.o_cl_busy), 256'(3'b111));
      chk("t1_wait_cmd", 256'(bus.o_command), 256'd0);
      cyc();
    end
    bus.i_dataInValid = 1'b1; bus.i_dataIn = D2;
    rd_q.push_back({3'b010, D2});
    smp();
    chk("t1_strobe", 256'(bus.o_cl_dataInValid), 256'(3'b010));
    chk("t1_busy_ret", 256'(bus.o_cl_busy), 256'(3'b111));
    cyc(); bus.i_dataInValid = 1'b0;
    smp();
    chk("t1_idle_gvalid", 256'(grant_valid), 256'd0);
    chk("t1_strobe_off", 256'(bus.o_cl_dataInValid), 256'd0);

    // All three clients stream writes from pointer 0.
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    for (int k = 0; k < 6; k++) push_acc(k % 3, 15'(15'h0100 + k % 3), 1'b1);
    for (int c = 0; c < 3; c++) set_cl(c, 1'b1, 1'b1, 15'(15'h0100 + c), D3);
    for (int w = 0; w < 6; w++) begin
      n = 0;
      for (int j = 0; j < 2; j++) begin
        smp();
        if (bus.o_command === 1'b1 && bus.i_busy === 1'b0) n++;
        cyc();
      end
      chk("t2_window_accepts", 256'(n), 256'd1);
    end
    for (int c = 0; c < 3; c++) set_cl(c, 1'b0, 1'b1, 15'(15'h0100 + c), D3);
    smp();
    chk("t2_queue_drained", 256'(acc_q.size()), 256'd0);
    chk("t2_idle", 256'(grant_valid), 256'd0);

    // Client-2 write held off by memory busy for 5 cycles.
    cyc(); bus.i_busy = 1'b1; set_cl(2, 1'b1, 1'b1, 15'h0ABC, D4);
    push_acc(2, 15'h0ABC, 1'b1);
    smp(); chk("t3_idle_busy", 256'(bus.o_cl_busy), 256'(3'b111));
    for (int i = 0; i < 4; i++) begin
      cyc(); smp();
      chk("t3_hold_cmd", 256'(bus.o_command), 256'd1);
      chk("t3_hold_adr", 256'(bus.o_adr), 256'h0ABC);
      chk("t3_hold_busy", 256'(bus.o_cl_busy), 256'(3'b111));
    end
    cyc(); bus.i_busy = 1'b0;
    smp();
    chk("t3_busy_follow", 256'(bus.o_cl_busy), 256'(3'b011));
    chk("t3_dout", bus.o_dataOut, D4);
    cyc(); set_cl(2, 1'b0, 1'b1, 15'h0ABC, D4);
    smp(); chk("t3_released", 256'(grant_valid), 256'd0);

    // Client-0 read outstanding while client 1 requests.
    push_acc(0, 15'h0011, 1'b0);
    cyc(); set_cl(0, 1'b1, 1'b0, 15'h0011, D1);
    smp();
    cyc();
    smp(); chk("t4_gidx0", 256'(grant_idx), 256'd0);
    cyc(); set_cl(0, 1'b0, 1'b0, 15'h0011, D1); set_cl(1, 1'b1, 1'b1, 15'h0022, D5);
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("t4_wait_gidx", 256'(grant_idx), 256'd0);
      chk("t4_wait_cmd", 256'(bus.o_command), 256'd0);
      chk("t4_wait_busy", 256'(bus.o_cl_busy), 256'(3'b111));
      cyc();
    end
    bus.i_dataInValid = 1'b1; bus.i_dataIn = D5;
    rd_q.push_back({3'b001, D5});
    push_acc(1, 15'h0022, 1'b1);
    smp(); chk("t4_strobe", 256'(bus.o_cl_dataInValid), 256'(3'b001));
    cyc(); bus.i_dataInValid = 1'b0;
    smp(); chk("t4_idle_gap", 256'(grant_valid), 256'd0);
    cyc();
    smp(); chk("t4_gidx1", 256'(grant_idx), 256'd1);
    cyc(); set_cl(1, 1'b0, 1'b1, 15'h0022, D5);

    // Stray read data in IDLE raises a sticky error.
    bus.i_dataInValid = 1'b1; bus.i_dataIn = D6;
    smp(); chk("t5_no_strobe", 256'(bus.o_cl_dataInValid), 256'd0);
    cyc(); bus.i_dataInValid = 1'b0;
    smp(); chk("t5_err", 256'(proto_err), 256'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(); smp();
      chk("t5_err_sticky", 256'(proto_err), 256'd1);
    end

    // Reset while a read is outstanding; late data is flagged.
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    smp(); chk("t6_err_clr", 256'(proto_err), 256'd0);
    push_acc(0, 15'h0033, 1'b0);
    cyc(); set_cl(0, 1'b1, 1'b0, 15'h0033, D1);
    smp();
    cyc();
    smp();
    cyc(); set_cl(0, 1'b0, 1'b0, 15'h0033, D1);
    smp(); chk("t6_wait_gvalid", 256'(grant_valid), 256'd1);
    cyc(); rst = 1'b1;
    smp();
    cyc(); rst = 1'b0;
    smp();
    chk("t6_rst_busy", 256'(bus.o_cl_busy), 256'(3'b111));
    chk("t6_rst_gvalid", 256'(grant_valid), 256'd0);
    chk("t6_rst_gidx", 256'(grant_idx), 256'd0);
    chk("t6_rst_cmd", 256'(bus.o_command), 256'd0);
    chk("t6_rst_dv", 256'(bus.o_cl_dataInValid), 256'd0);
    cyc(); bus.i_dataInValid = 1'b1; bus.i_dataIn = D7;
    smp(); chk("t6_late_no_strobe", 256'(bus.o_cl_dataInValid), 256'd0);
    cyc(); bus.i_dataInValid = 1'b0;
    smp(); chk("t6_late_err", 256'(proto_err), 256'd1);
    push_acc(2, 15'h0044, 1'b1);
    cyc(); set_cl(2, 1'b1, 1'b1, 15'h0044, D2);
    smp();
    cyc();
    smp();
    chk("t6_regrant_idx", 256'(grant_idx), 256'd2);
    chk("t6_regrant_busy", 256'(bus.o_cl_busy), 256'(3'b011));
    cyc(); set_cl(2, 1'b0, 1'b1, 15'h0044, D2);
    smp(); chk("t6_err_stays", 256'(proto_err), 256'd1);

    chk("end_acc_queue", 256'(acc_q.size()), 256'd0);
    chk("end_rd_queue", 256'(rd_q.size()), 256'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
